water_valve_arbiter: RTL

WATER_VALVE_ARBITER -- requirements
Module: water_valve_arbiter

---
 rtl/water_valve_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/water_valve_arbiter.sv
// water_valve_arbiter
//   Round-robin arbiter for one shared water inlet valve serving four machines.
//   A granted machine keeps the valve for a fixed fill time of
//   FILL_TICKS * TICK_DIV clock cycles. Supply pauses freeze that time, and the
//   machine can give up the valve early by dropping its request.
//
// Ports
//   clock         system clock, rising edge active
//   rst_n         asynchronous active-low reset
//   req[3:0]      per-machine fill request (level)
//   supply_pause  global supply hold: freezes the active fill, blocks new grants
//   grant[3:0]    one-hot valve owner (registered), zero when nobody owns it
//   owner[1:0]    index of the current or most recent grantee (registered)
//   valve_open    high while a fill is actively running
//   fill_done     one-cycle pulse on the bit of the machine whose fill completed
//   busy          high whenever the arbiter is not idle
module water_valve_arbiter #(
  parameter int unsigned TICK_DIV   = 16,
  parameter int unsigned FILL_TICKS = 8
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       supply_pause,
  output logic [3:0] grant,
  output logic [1:0] owner,
  output logic       valve_open,
  output logic [3:0] fill_done,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, FILL, HOLD, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [15:0] presc_q, presc_d;
  logic [7:0]  ticks_q, ticks_d;
  logic [1:0]  owner_q, owner_d;
  logic [3:0]  grant_q, grant_d;
  logic [3:0]  fill_done_q, fill_done_d;
  logic        valve_open_q, valve_open_d;
  logic        busy_q, busy_d;

  logic        sel_found;
  logic [1:0]  sel_idx;
  logic [15:0] presc_step;
  logic [7:0]  ticks_step;
  logic        presc_wrap;

  // Round-robin search starting at rr_ptr. The loop runs from the farthest
  // offset down so the nearest requester is the one left in sel_idx.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = rr_ptr_q;
    for (int i = 3; i >= 0; i--) begin
      if (req[rr_ptr_q + 2'(i)]) begin
        sel_found = 1'b1;
        sel_idx   = rr_ptr_q + 2'(i);
      end
    end
  end

  // One fill cycle's worth of progress on the prescaler/tick pair.
  always_comb begin
    presc_wrap = (presc_q == 16'(TICK_DIV - 1));
    presc_step = presc_wrap ? 16'd0 : presc_q + 16'd1;
    ticks_step = presc_wrap ? ticks_q + 8'd1 : ticks_q;
  end

  // Next-state logic. In FILL the progress of the current cycle is kept even
  // when moving to HOLD, because the valve was open during that cycle. If that
  // cycle happened to be the last one of the fill, HOLD finishes the fill
  // straight into DONE once the pause lifts, so no extra FILL cycle is spent.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    presc_d  = presc_q;
    ticks_d  = ticks_q;
    owner_d  = owner_q;
    unique case (state_q)
      IDLE: begin
        if (!supply_pause && sel_found) begin
          owner_d = sel_idx;
          state_d = FILL;
        end
      end
      FILL: begin
        if (!req[owner_q]) begin
          state_d  = IDLE;
          rr_ptr_d = owner_q + 2'd1;
          presc_d  = '0;
          ticks_d  = '0;
        end else begin
          presc_d = presc_step;
          ticks_d = ticks_step;
          if (supply_pause) begin
            state_d = HOLD;
          end else if (ticks_step == 8'(FILL_TICKS)) begin
            state_d = DONE;
            presc_d = '0;
            ticks_d = '0;
          end
        end
      end
      HOLD: begin
        if (!req[owner_q]) begin
          state_d  = IDLE;
          rr_ptr_d = owner_q + 2'd1;
          presc_d  = '0;
          ticks_d  = '0;
        end else if (!supply_pause) begin
          if (ticks_q == 8'(FILL_TICKS)) begin
            state_d = DONE;
            presc_d = '0;
            ticks_d = '0;
          end else begin
            state_d = FILL;
          end
        end
      end
      DONE: begin
        state_d  = IDLE;
        rr_ptr_d = owner_q + 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet line
  // up with the state they describe.
  always_comb begin
    grant_d      = (state_d == FILL || state_d == HOLD) ? (4'b0001 << owner_d) : 4'b0000;
    fill_done_d  = (state_d == DONE) ? (4'b0001 << owner_d) : 4'b0000;
    valve_open_d = (state_d == FILL);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      presc_q      <= '0;
      ticks_q      <= '0;
      owner_q      <= '0;
      grant_q      <= '0;
      fill_done_q  <= '0;
      valve_open_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      presc_q      <= presc_d;
      ticks_q      <= ticks_d;
      owner_q      <= owner_d;
      grant_q      <= grant_d;
      fill_done_q  <= fill_done_d;
      valve_open_q <= valve_open_d;
      busy_q       <= busy_d;
    end
  end

  assign grant      = grant_q;
  assign owner      = owner_q;
  assign valve_open = valve_open_q;
  assign fill_done  = fill_done_q;
  assign busy       = busy_q;

endmodule
